// File: rtl/alu16_stream_if.sv
// Request/result channel bundle for alu16_stream.
// The slave modport is the ALU side; the master modport is the producer/consumer side.
interface alu16_stream_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_cout;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_cout
    );
endinterface

// File: rtl/alu16_stream.sv
// Handshaked 16-bit ALU front end: one registered compute stage feeding a
// circular result FIFO. Admission is throttled by total occupancy (stage +
// FIFO) so the stage can always push unconditionally.
module alu16_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu16_stream_if.slave    bus,
    output logic [CNT_W-1:0] done_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 2);

    logic             in_fire;
    logic             out_fire;
    logic             stage_valid;
    logic [WIDTH-1:0] stage_y;
    logic             stage_cout;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_y;
    logic             res_cout;
    logic [WIDTH-1:0] y_mem [DEPTH];
    logic             c_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] fifo_count;
    logic [OCC_W-1:0] occ;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on registered occupancy, never on in_valid/out_ready.
    assign occ          = OCC_W'(stage_valid) + fifo_count;
    assign bus.in_ready = (occ < OCC_W'(DEPTH));
    assign in_fire      = bus.in_valid & bus.in_ready;

    assign bus.out_valid = (fifo_count != '0);
    assign out_fire      = bus.out_valid & bus.out_ready;
    assign bus.out_y     = bus.out_valid ? y_mem[rd_ptr] : '0;
    assign bus.out_cout  = bus.out_valid ? c_mem[rd_ptr] : 1'b0;

    // ALU datapath on unsigned operands; SUB carry means "no borrow".
    always_comb begin
        sum      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        res_y    = '0;
        res_cout = 1'b0;
        case (bus.in_op)
            2'b00: begin
                res_y    = sum[WIDTH-1:0];
                res_cout = sum[WIDTH];
            end
            2'b01: begin
                res_y    = bus.in_a - bus.in_b;
                res_cout = (bus.in_a >= bus.in_b);
            end
            2'b10:   res_y = bus.in_a & bus.in_b;
            default: res_y = bus.in_a | bus.in_b;
        endcase
    end

    // Compute stage: captures a result on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_y     <= '0;
            stage_cout  <= 1'b0;
        end else begin
            stage_valid <= in_fire;
            if (in_fire) begin
                stage_y    <= res_y;
                stage_cout <= res_cout;
            end
        end
    end

    // FIFO storage: the stage result is written whenever the stage is valid.
    always_ff @(posedge clk) begin
        if (stage_valid) begin
            y_mem[wr_ptr] <= stage_y;
            c_mem[wr_ptr] <= stage_cout;
        end
    end

    // FIFO pointers and count; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (stage_valid) wr_ptr <= ptr_next(wr_ptr);
            if (out_fire)    rd_ptr <= ptr_next(rd_ptr);
            case ({stage_valid, out_fire})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Completed-operation counter, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_count <= '0;
        else if (out_fire) done_count <= done_count + 1'b1;
    end
endmodule

// File: tb/tb_alu16_stream.sv
// Directed bench for alu16_stream: ordering, latency, back-pressure,
// streaming throughput, randomized handshakes, counter wrap and mid-run reset.
module tb_alu16_stream;
    logic        clk;
    logic        rst_n;
    logic [15:0] done_count;
    logic [3:0]  done2;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    alu16_stream_if #(.WIDTH(16)) u_if ();
    alu16_stream_if #(.WIDTH(16)) u_if2 ();

    alu16_stream #(.WIDTH(16), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if.slave), .done_count(done_count)
    );

    alu16_stream #(.WIDTH(16), .DEPTH(4), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(u_if2.slave), .done_count(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        logic [16:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {(a >= b), 16'(a - b)};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    // Handshakes seen on the falling edge complete at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.in_valid && u_if.in_ready) begin
                exp_q.push_back(model(u_if.in_a, u_if.in_b, u_if.in_op));
                acc_cnt++;
            end
            if (u_if.out_valid && u_if.out_ready)
                got_q.push_back({u_if.out_cout, u_if.out_y});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stall the output and push ADD requests a=1111*(k+1), b=1 until stop_at or 8 cycles.
    task automatic fill(input int stop_at, output int taken);
        int   k;
        logic took;
        k = 0;
        u_if.out_ready = 1'b0;
        u_if.in_op     = 2'b00;
        u_if.in_b      = 16'h0001;
        u_if.in_a      = 16'h1111;
        u_if.in_valid  = 1'b1;
        for (int i = 0; i < 8 && k < stop_at; i++) begin
            @(negedge clk);
            took = u_if.in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                k++;
                u_if.in_a = 16'(16'h1111 * (k + 1));
            end
        end
        u_if.in_valid = 1'b0;
        taken = k;
    endtask

    initial begin
        int taken;
        int acc0;
        int cycles;
        int stalls;
        int bad;
        int seed;
        logic found;
        logic [15:0] d0;

        rst_n = 1'b0;
        u_if.in_valid = 0;  u_if.in_a = 0;  u_if.in_b = 0;  u_if.in_op = 0;  u_if.out_ready = 0;
        u_if2.in_valid = 0; u_if2.in_a = 0; u_if2.in_b = 0; u_if2.in_op = 0; u_if2.out_ready = 0;

        // Reset state
        settle(3);
        check("rst_out_valid", u_if.out_valid, 0);
        check("rst_out_y", u_if.out_y, 0);
        check("rst_out_cout", u_if.out_cout, 0);
        check("rst_done_count", done_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", u_if.in_ready, 1);

        // done_count wrap on the CNT_W=4 instance
        @(posedge clk); #1;
        u_if2.in_valid = 1; u_if2.out_ready = 1; u_if2.in_a = 16'h0003; u_if2.in_b = 16'h0004;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done2 == 4'd15) found = 1'b1;
        end
        check("wrap_reach15", found, 1);
        @(negedge clk);
        check("wrap_to_0", done2, 0);
        @(posedge clk); #1;
        u_if2.in_valid = 0;

        // Test 1: F0F0 / 0FF0 through all four ops, back-to-back
        got_q.delete();
        u_if.out_ready = 1;
        u_if.in_a = 16'hF0F0; u_if.in_b = 16'h0FF0; u_if.in_op = 2'b00; u_if.in_valid = 1;
        @(posedge clk); #1;
        u_if.in_op = 2'b01;
        @(negedge clk);
        check("t1_latency_1cyc", u_if.out_valid, 0);
        @(posedge clk); #1;
        u_if.in_op = 2'b10;
        @(negedge clk);
        check("t1_latency_2cyc", u_if.out_valid, 1);
        check("t1_first_head", {u_if.out_cout, u_if.out_y}, 17'h100E0);
        @(posedge clk); #1;
        u_if.in_op = 2'b11;
        @(posedge clk); #1;
        u_if.in_valid = 0;
        settle(4);
        check("t1_count", got_q.size(), 4);
        check("t1_add", got_q[0], 17'h100E0);
        check("t1_sub", got_q[1], 17'h1E100);
        check("t1_and", got_q[2], 17'h000F0);
        check("t1_or", got_q[3], 17'h0FFF0);

        // Test 2: borrow and carry boundaries
        got_q.delete();
        u_if.in_a = 16'h0001; u_if.in_b = 16'h0002; u_if.in_op = 2'b01; u_if.in_valid = 1;
        @(posedge clk); #1;
        u_if.in_a = 16'hFFFF; u_if.in_b = 16'h0001; u_if.in_op = 2'b00;
        @(posedge clk); #1;
        u_if.in_valid = 0;
        settle(4);
        check("t2_count", got_q.size(), 2);
        check("t2_sub_borrow", got_q[0], 17'h0FFFF);
        check("t2_add_carry", got_q[1], 17'h10000);

        // Test 3: back-pressure admits exactly DEPTH requests, head stays stable
        got_q.delete();
        fill(99, taken);
        check("t3_accepted", taken, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_in_ready_low", u_if.in_ready, 0);
            check("t3_head_stable", {u_if.out_valid, u_if.out_cout, u_if.out_y}, 18'h21112);
        end
        @(posedge clk); #1;
        u_if.out_ready = 1;
        settle(6);
        check("t3_drain_count", got_q.size(), 4);
        check("t3_drain0", got_q[0], 17'h01112);
        check("t3_drain1", got_q[1], 17'h02223);
        check("t3_drain2", got_q[2], 17'h03334);
        check("t3_drain3", got_q[3], 17'h04445);
        check("t3_in_ready_back", u_if.in_ready, 1);
        check("t3_empty", u_if.out_valid, 0);

        // Test 4: 100 cycles of continuous streaming
        got_q.delete();
        d0 = done_count;
        stalls = 0;
        u_if.in_valid = 1; u_if.in_b = 16'h0005; u_if.in_op = 2'b00;
        for (int i = 0; i < 100; i++) begin
            u_if.in_a = 16'(i);
            @(negedge clk);
            if (!u_if.in_ready) stalls++;
            @(posedge clk); #1;
        end
        u_if.in_valid = 0;
        @(negedge clk);
        check("t4_done_delta", 16'(done_count - d0), 98);
        check("t4_no_stalls", stalls, 0);
        settle(4);
        check("t4_count", got_q.size(), 100);
        bad = 0;
        for (int i = 0; i < 100; i++)
            if (got_q[i] !== 17'(i + 5)) bad++;
        check("t4_order", bad, 0);

        // Test 5: random handshakes against the reference queue
        got_q.delete();
        exp_q.delete();
        seed = $urandom(32'd20240611);
        acc0 = acc_cnt;
        cycles = 0;
        while ((acc_cnt - acc0) < 10000 && cycles < 40000) begin
            u_if.in_valid  = ($urandom_range(0, 3) != 0);
            u_if.out_ready = ($urandom_range(0, 3) != 0);
            u_if.in_a      = 16'($urandom);
            u_if.in_b      = 16'($urandom);
            u_if.in_op     = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            cycles++;
        end
        u_if.in_valid = 0;
        u_if.out_ready = 1;
        while (got_q.size() < exp_q.size() && cycles < 40100) begin
            settle(1);
            cycles++;
        end
        settle(3);
        check("t5_accepted", acc_cnt - acc0, 10000);
        check("t5_count", got_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check("t5_content", bad, 0);

        // Test 6: reset with stage full and three buffered results
        got_q.delete();
        fill(4, taken);
        check("t6_accepted", taken, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", u_if.out_valid, 0);
        check("t6_rst_done", done_count, 0);
        check("t6_rst_out_y", {u_if.out_cout, u_if.out_y}, 0);
        @(posedge clk); #1;
        u_if.out_ready = 1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_in_ready", u_if.in_ready, 1);
        settle(6);
        check("t6_no_stale", got_q.size(), 0);
        check("t6_done_after", done_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
